// File: rtl/inpdt_seq_ctrl.sv
// -----------------------------------------------------------------------------
// inpdt_seq_ctrl
//   Sequencer for the 16-lane signed inner-product datapath of the LSTM gate
//   matrix-vector product. For each output row it reads N_CHUNK 16-element
//   chunks of XH and of the weight row from sync-read buffers. It enables the
//   inner-product unit in each buffer data cycle and accumulates the 21-bit
//   chunk results into a signed row sum. Each row sum is returned over a
//   valid/ready handshake.
//
// Ports
//   iClk, iRstn     clock, asynchronous active-low reset
//   iStart          job start, sampled only while idle
//   iAbort          synchronous abort, returns to idle on the next cycle
//   oRd_en          buffer read strobe
//   oXH_addr        XH chunk address (= chunk)
//   oW_addr         weight address (= row*N_CHUNK + chunk)
//   oInpdt_en       inner-product enable (oRd_en delayed one cycle)
//   iInpdt_res      signed 21-bit chunk result, valid while oInpdt_en is high
//   oValid/iReady   row-sum handshake
//   oAcc, oRow      signed row sum and its row index
//   oBusy           high whenever the sequencer is not idle
//   oDone           one-cycle pulse after the last row is accepted
// -----------------------------------------------------------------------------
module inpdt_seq_ctrl #(
    parameter int N_CHUNK = 8,
    parameter int N_ROW   = 4,
    parameter int ACC_W   = 32,
    localparam int CW = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1,
    localparam int WW = ((N_ROW * N_CHUNK) > 1) ? $clog2(N_ROW * N_CHUNK) : 1,
    localparam int RW = (N_ROW > 1) ? $clog2(N_ROW) : 1
) (
    input  logic                    iClk,
    input  logic                    iRstn,
    input  logic                    iStart,
    input  logic                    iAbort,
    output logic                    oRd_en,
    output logic [CW-1:0]           oXH_addr,
    output logic [WW-1:0]           oW_addr,
    output logic                    oInpdt_en,
    input  logic signed [20:0]      iInpdt_res,
    output logic                    oValid,
    input  logic                    iReady,
    output logic signed [ACC_W-1:0] oAcc,
    output logic [RW-1:0]           oRow,
    output logic                    oBusy,
    output logic                    oDone
);

    if (ACC_W < 22 + $clog2(N_CHUNK)) begin : g_acc_w_check
        $error("inpdt_seq_ctrl: ACC_W too narrow for N_CHUNK chunk results");
    end

    localparam logic [CW-1:0] LAST_CHUNK = CW'(N_CHUNK - 1);
    localparam logic [RW-1:0] LAST_ROW   = RW'(N_ROW - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LAST,
        S_OUT,
        S_DONE
    } state_t;

    state_t state;

    // Marks that the data arriving with oInpdt_en belongs to chunk 0,
    // so the accumulator restarts instead of adding to the previous row.
    logic first_q;

    logic [ACC_W-1:0] res_ext;
    assign res_ext = {{(ACC_W - 21){iInpdt_res[20]}}, iInpdt_res};

    assign oBusy = (state != S_IDLE);

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            state     <= S_IDLE;
            oRd_en    <= 1'b0;
            oXH_addr  <= '0;
            oW_addr   <= '0;
            oInpdt_en <= 1'b0;
            first_q   <= 1'b0;
            oValid    <= 1'b0;
            oAcc      <= '0;
            oRow      <= '0;
            oDone     <= 1'b0;
        end else if (iAbort) begin
            // Abort discards in-flight buffer data along with the partial sum.
            state     <= S_IDLE;
            oRd_en    <= 1'b0;
            oXH_addr  <= '0;
            oW_addr   <= '0;
            oInpdt_en <= 1'b0;
            first_q   <= 1'b0;
            oValid    <= 1'b0;
            oAcc      <= '0;
            oRow      <= '0;
            oDone     <= 1'b0;
        end else begin
            oInpdt_en <= oRd_en;
            first_q   <= oRd_en && (oXH_addr == '0);
            oDone     <= 1'b0;

            if (oInpdt_en) begin
                oAcc <= (first_q ? '0 : oAcc) + res_ext;
            end

            case (state)
                S_IDLE: begin
                    if (iStart) begin
                        state    <= S_FETCH;
                        oRd_en   <= 1'b1;
                        oXH_addr <= '0;
                        oW_addr  <= '0;
                        oRow     <= '0;
                    end
                end

                // oW_addr is a running counter; after a row's last fetch it
                // already points at the base of the next row.
                S_FETCH: begin
                    oW_addr <= oW_addr + 1'b1;
                    if (oXH_addr == LAST_CHUNK) begin
                        state    <= S_LAST;
                        oRd_en   <= 1'b0;
                        oXH_addr <= '0;
                    end else begin
                        oXH_addr <= oXH_addr + 1'b1;
                    end
                end

                S_LAST: begin
                    state  <= S_OUT;
                    oValid <= 1'b1;
                end

                S_OUT: begin
                    if (iReady) begin
                        oValid <= 1'b0;
                        if (oRow == LAST_ROW) begin
                            state <= S_DONE;
                            oDone <= 1'b1;
                        end else begin
                            state  <= S_FETCH;
                            oRd_en <= 1'b1;
                            oRow   <= oRow + 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inpdt_seq_ctrl.sv
module tb_inpdt_seq_ctrl;

    // ---------------- main DUT (defaults: 8 chunks, 4 rows) ----------------
    logic               iClk;
    logic               iRstn;
    logic               iStart;
    logic               iAbort;
    logic               oRd_en;
    logic [2:0]         oXH_addr;
    logic [4:0]         oW_addr;
    logic               oInpdt_en;
    logic signed [20:0] iInpdt_res;
    logic               oValid;
    logic               iReady;
    logic signed [31:0] oAcc;
    logic [1:0]         oRow;
    logic               oBusy;
    logic               oDone;

    inpdt_seq_ctrl #(.N_CHUNK(8), .N_ROW(4), .ACC_W(32)) u_dut (
        .iClk(iClk), .iRstn(iRstn), .iStart(iStart), .iAbort(iAbort),
        .oRd_en(oRd_en), .oXH_addr(oXH_addr), .oW_addr(oW_addr),
        .oInpdt_en(oInpdt_en), .iInpdt_res(iInpdt_res),
        .oValid(oValid), .iReady(iReady), .oAcc(oAcc), .oRow(oRow),
        .oBusy(oBusy), .oDone(oDone)
    );

    // ---------------- small DUT (1 chunk, 1 row) ----------------
    logic               iStart1;
    logic               iAbort1;
    logic               oRd_en1;
    logic [0:0]         oXH_addr1;
    logic [0:0]         oW_addr1;
    logic               oInpdt_en1;
    logic signed [20:0] iInpdt_res1;
    logic               oValid1;
    logic               iReady1;
    logic signed [31:0] oAcc1;
    logic [0:0]         oRow1;
    logic               oBusy1;
    logic               oDone1;

    inpdt_seq_ctrl #(.N_CHUNK(1), .N_ROW(1), .ACC_W(32)) u_dut1 (
        .iClk(iClk), .iRstn(iRstn), .iStart(iStart1), .iAbort(iAbort1),
        .oRd_en(oRd_en1), .oXH_addr(oXH_addr1), .oW_addr(oW_addr1),
        .oInpdt_en(oInpdt_en1), .iInpdt_res(iInpdt_res1),
        .oValid(oValid1), .iReady(iReady1), .oAcc(oAcc1), .oRow(oRow1),
        .oBusy(oBusy1), .oDone(oDone1)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // ---------------- buffer + inner-product model ----------------
    // Addresses are captured on the read strobe; the result is meaningful
    // only in the following data cycle, otherwise a junk value is driven.
    int         kind;
    logic [2:0] xh_q;
    logic [4:0] w_q;
    logic       dv_q;
    logic       dv1_q;

    always @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            dv_q  <= 1'b0;
            dv1_q <= 1'b0;
            xh_q  <= '0;
            w_q   <= '0;
        end else begin
            dv_q  <= oRd_en;
            dv1_q <= oRd_en1;
            if (oRd_en) begin
                xh_q <= oXH_addr;
                w_q  <= oW_addr;
            end
        end
    end

    function automatic logic signed [20:0] res_fn(input int k, input logic [2:0] xh,
                                                  input logic [4:0] w);
        int v;
        case (k)
            0:       v = 16;
            1:       v = -1044480;
            2:       v = int'(w);
            3:       v = int'(xh) * 100 - 300;
            default: v = w[0] ? -1048576 : 1048575;
        endcase
        return 21'(v);
    endfunction

    always_comb begin
        iInpdt_res  = dv_q  ? res_fn(kind, xh_q, w_q) : 21'sh05A5A;
        iInpdt_res1 = dv1_q ? -21'sd5 : 21'sd777;
    end

    // ---------------- checking ----------------
    int compared;
    int mismatched;
    int cyc;

    task automatic chk(input string name, input longint act, input longint exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        string name;
        int    k;
        int    e0, e1, e2, e3;
        bit    timing;
    } vec_t;

    vec_t vecs[5];

    // One full job with iReady high; checks each row sum and index, and
    // optionally the first-valid and done cycle numbers.
    task automatic run_job(input string tag, input int k, input int e0, input int e1,
                           input int e2, input int e3, input bit timing);
        int exp_r[4];
        int guard;
        exp_r  = '{e0, e1, e2, e3};
        kind   = k;
        iReady = 1'b1;
        iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        cyc    = 1;
        for (int r = 0; r < 4; r++) begin
            guard = 0;
            while (!oValid && guard < 40) begin
                @(negedge iClk);
                cyc++;
                guard++;
            end
            chk({tag, "_valid"}, longint'(oValid), 1);
            if (timing && r == 0) chk({tag, "_first_valid_cycle"}, cyc, 10);
            chk({tag, "_acc"}, longint'(oAcc), exp_r[r]);
            chk({tag, "_row"}, longint'(oRow), r);
            @(negedge iClk);
            cyc++;
        end
        guard = 0;
        while (!oDone && guard < 10) begin
            @(negedge iClk);
            cyc++;
            guard++;
        end
        chk({tag, "_done"}, longint'(oDone), 1);
        if (timing) chk({tag, "_done_cycle"}, cyc, 41);
        @(negedge iClk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int guard;
        int done_seen;
        compared   = 0;
        mismatched = 0;
        kind       = 0;

        vecs[0] = '{"t1_ones",    0, 128, 128, 128, 128, 1'b1};
        vecs[1] = '{"t2_neg",     1, -8355840, -8355840, -8355840, -8355840, 1'b0};
        vecs[2] = '{"waddr_sum",  2, 28, 92, 156, 220, 1'b0};
        vecs[3] = '{"xh_ramp",    3, 400, 400, 400, 400, 1'b0};
        vecs[4] = '{"extremes",   4, -4, -4, -4, -4, 1'b0};

        iRstn   = 1'b0;
        iStart  = 1'b0;
        iAbort  = 1'b0;
        iReady  = 1'b0;
        iStart1 = 1'b0;
        iAbort1 = 1'b0;
        iReady1 = 1'b0;

        // reset state
        repeat (2) @(negedge iClk);
        chk("rst_valid", longint'(oValid), 0);
        chk("rst_busy",  longint'(oBusy), 0);
        chk("rst_rd_en", longint'(oRd_en), 0);
        chk("rst_acc",   longint'(oAcc), 0);
        chk("rst_done",  longint'(oDone), 0);
        iRstn = 1'b1;
        @(negedge iClk);

        // table-driven jobs
        foreach (vecs[i]) begin
            run_job(vecs[i].name, vecs[i].k, vecs[i].e0, vecs[i].e1,
                    vecs[i].e2, vecs[i].e3, vecs[i].timing);
        end

        // T3: consumer stalls row 1 for 5 cycles
        kind   = 0;
        iReady = 1'b0;
        iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        guard  = 0;
        while (!oValid && guard < 40) begin @(negedge iClk); guard++; end
        chk("t3_row0", longint'(oRow), 0);
        iReady = 1'b1;
        @(negedge iClk);
        iReady = 1'b0;
        guard  = 0;
        while (!oValid && guard < 40) begin @(negedge iClk); guard++; end
        for (int i = 0; i < 5; i++) begin
            chk("t3_stall_valid", longint'(oValid), 1);
            chk("t3_stall_acc",   longint'(oAcc), 128);
            chk("t3_stall_row",   longint'(oRow), 1);
            chk("t3_stall_rd_en", longint'(oRd_en), 0);
            @(negedge iClk);
        end
        iReady = 1'b1;
        @(negedge iClk);
        chk("t3_fetch_rd_en", longint'(oRd_en), 1);
        chk("t3_fetch_valid", longint'(oValid), 0);
        chk("t3_fetch_xh",    longint'(oXH_addr), 0);
        chk("t3_fetch_w",     longint'(oW_addr), 16);
        guard = 0;
        while (!oDone && guard < 40) begin @(negedge iClk); guard++; end
        chk("t3_done", longint'(oDone), 1);
        @(negedge iClk);

        // T4: abort on the 3rd fetch cycle of row 2
        kind   = 1;
        iReady = 1'b1;
        iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        guard  = 0;
        while (!(oValid && oRow == 2'd1) && guard < 40) begin @(negedge iClk); guard++; end
        chk("t4_row1_valid", longint'(oValid), 1);
        @(negedge iClk);
        chk("t4_fetch1_w", longint'(oW_addr), 16);
        @(negedge iClk);
        @(negedge iClk);
        chk("t4_fetch3_xh", longint'(oXH_addr), 2);
        iAbort = 1'b1;
        @(negedge iClk);
        iAbort = 1'b0;
        chk("t4_busy",     longint'(oBusy), 0);
        chk("t4_rd_en",    longint'(oRd_en), 0);
        chk("t4_inpdt_en", longint'(oInpdt_en), 0);
        chk("t4_valid",    longint'(oValid), 0);
        chk("t4_acc",      longint'(oAcc), 0);
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (oDone) done_seen++;
            @(negedge iClk);
        end
        chk("t4_no_done", done_seen, 0);
        run_job("t4_rerun", 0, 128, 128, 128, 128, 1'b1);

        // T5: asynchronous reset while a row is waiting in OUT
        kind   = 1;
        iReady = 1'b0;
        iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        guard  = 0;
        while (!oValid && guard < 40) begin @(negedge iClk); guard++; end
        chk("t5_out_acc", longint'(oAcc), -8355840);
        #2 iRstn = 1'b0;
        #1;
        chk("t5_valid", longint'(oValid), 0);
        chk("t5_busy",  longint'(oBusy), 0);
        chk("t5_acc",   longint'(oAcc), 0);
        iStart = 1'b1;
        repeat (3) @(negedge iClk);
        chk("t5_start_in_reset", longint'(oBusy), 0);
        iStart = 1'b0;
        iRstn  = 1'b1;
        @(negedge iClk);
        chk("t5_after_release", longint'(oBusy), 0);
        run_job("t5_rerun", 0, 128, 128, 128, 128, 1'b1);

        // T6: 1 chunk, 1 row, start held high throughout
        iReady1 = 1'b1;
        iStart1 = 1'b1;
        @(negedge iClk);
        chk("t6_c1_rd_en", longint'(oRd_en1), 1);
        chk("t6_c1_busy",  longint'(oBusy1), 1);
        @(negedge iClk);
        chk("t6_c2_inpdt_en", longint'(oInpdt_en1), 1);
        chk("t6_c2_rd_en",    longint'(oRd_en1), 0);
        @(negedge iClk);
        chk("t6_c3_valid", longint'(oValid1), 1);
        chk("t6_c3_acc",   longint'(oAcc1), -5);
        chk("t6_c3_row",   longint'(oRow1), 0);
        @(negedge iClk);
        chk("t6_c4_done", longint'(oDone1), 1);
        @(negedge iClk);
        chk("t6_c5_idle", longint'(oBusy1), 0);
        chk("t6_c5_done", longint'(oDone1), 0);
        @(negedge iClk);
        chk("t6_c6_restart", longint'(oBusy1), 1);
        iStart1 = 1'b0;
        guard   = 0;
        while (!oDone1 && guard < 10) begin @(negedge iClk); guard++; end
        chk("t6_second_done", longint'(oDone1), 1);
        @(negedge iClk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
